dmem_arbiter: RTL and testbench

- Shares the single-port synchronous data memory between two requesters.
- Requester 0 is the CPU load/store stage; requester 1 is the debug loader / DMA port.
- Per-cycle grant is round-robin, with an optional bounded lock for requester 1 so it can perform atomic read-modify-write sequences.
- Read data returns to the issuing requester after a fixed memory latency, tagged with an rvalid strobe.

---
 rtl/dmem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: round-robin with a bounded lock for requester 1.
// Latency: grant and memory drive are combinational in the request cycle; read data returns READ_LATENCY cycles later.
// Backpressure: a requester holds req and its fields stable until gnt; the loser of a conflict simply waits.
module dmem_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_HOLD     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              lock1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              locked
);

    typedef enum logic {
        ST_OPEN  = 1'b0,
        ST_LOCK1 = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_last;
    logic                    w_last_nxt;
    logic [7:0]              r_hold;
    logic [7:0]              w_hold_nxt;
    logic                    w_gnt0;
    logic                    w_gnt1;
    logic                    w_hold_max;
    logic                    w_rd_issue;
    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [READ_LATENCY-1:0] r_pipe_id;

    assign w_hold_max = (r_hold >= HOLD_MAX);

    // Arbitration decision and next arbiter state from current requests.
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold;
        case (r_state)
            ST_OPEN: begin
                if (req0 && req1) begin
                    // last == 1 means requester 0 is next in the rotation
                    w_gnt0 = r_last;
                    w_gnt1 = ~r_last;
                end else if (req0) begin
                    w_gnt0 = 1'b1;
                end else if (req1) begin
                    w_gnt1 = 1'b1;
                end
                if (w_gnt0) begin
                    w_last_nxt = 1'b0;
                end
                if (w_gnt1) begin
                    w_last_nxt = 1'b1;
                    if (lock1) begin
                        w_state_nxt = ST_LOCK1;
                        w_hold_nxt  = 8'd1;
                    end
                end
            end
            ST_LOCK1: begin
                if (req1 && !w_hold_max) begin
                    w_gnt1     = 1'b1;
                    w_hold_nxt = r_hold + 8'd1;
                    if (!lock1) begin
                        w_state_nxt = ST_OPEN;
                        w_hold_nxt  = 8'd0;
                        w_last_nxt  = 1'b1;
                    end
                end else if (req1 && req0) begin
                    // hold budget exhausted: force one access for requester 0
                    w_gnt0      = 1'b1;
                    w_state_nxt = ST_OPEN;
                    w_hold_nxt  = 8'd0;
                    w_last_nxt  = 1'b0;
                end else if (req1) begin
                    // budget exhausted but nobody is waiting: keep serving 1
                    w_gnt1 = 1'b1;
                    if (!lock1) begin
                        w_state_nxt = ST_OPEN;
                        w_hold_nxt  = 8'd0;
                        w_last_nxt  = 1'b1;
                    end
                end else begin
                    // requester 1 let go; requester 0 may use the slot at once
                    w_state_nxt = ST_OPEN;
                    w_hold_nxt  = 8'd0;
                    w_gnt0      = req0;
                    w_last_nxt  = ~req0;
                end
            end
            default: begin
                w_state_nxt = ST_OPEN;
                w_hold_nxt  = 8'd0;
                w_last_nxt  = 1'b1;
            end
        endcase
    end

    // Grants are suppressed while reset is held.
    always_comb begin
        gnt0 = w_gnt0 & ~rst;
        gnt1 = w_gnt1 & ~rst;
    end

    // Memory port follows the granted requester; idle drives zeros.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (gnt0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_we    = we0;
        end else if (gnt1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_we    = we1;
        end
    end

    assign w_rd_issue = (gnt0 & ~we0) | (gnt1 & ~we1);

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_OPEN;
            r_last  <= 1'b1;
            r_hold  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Read-return tracker: one stage per cycle of memory latency, tagged with requester id.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld <= '0;
            r_pipe_id  <= '0;
        end else begin
            r_pipe_vld[0] <= w_rd_issue;
            r_pipe_id[0]  <= gnt1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_id[i]  <= r_pipe_id[i-1];
            end
        end
    end

    // Return strobes and status; both data outputs see the memory directly.
    always_comb begin
        rvalid0 = ~rst & r_pipe_vld[READ_LATENCY-1] & ~r_pipe_id[READ_LATENCY-1];
        rvalid1 = ~rst & r_pipe_vld[READ_LATENCY-1] &  r_pipe_id[READ_LATENCY-1];
        rdata0  = mem_rdata;
        rdata1  = mem_rdata;
        locked  = ~rst & (r_state == ST_LOCK1);
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (read latency 1 and 3) share stimulus and a memory model.
// Latency: expected read returns are derived from an issue history indexed by cycle.
// Backpressure: stimulus holds each request stable until the reference model grants it.
module tb_dmem_arbiter;
    localparam int AW   = 14;
    localparam int DW   = 32;
    localparam int MAXH = 8;
    localparam int HN   = 4096;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, req0, we0, req1, we1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;

    logic          gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, mem_we_a, locked_a;
    logic [DW-1:0] rdata0_a, rdata1_a, mem_wdata_a;
    logic [AW-1:0] mem_addr_a;
    logic          gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, mem_we_b, locked_b;
    logic [DW-1:0] rdata0_b, rdata1_b, mem_wdata_b;
    logic [AW-1:0] mem_addr_b;

    logic [DW-1:0] rd_l1;
    logic [DW-1:0] rd_l3 [0:2];
    logic [DW-1:0] tb_mem [0:(1<<AW)-1];
    bit            tb_wr  [0:(1<<AW)-1];

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .MAX_HOLD(MAXH)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0_a), .rvalid0(rvalid0_a), .rdata0(rdata0_a),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1_a), .rvalid1(rvalid1_a), .rdata1(rdata1_a),
        .lock1(lock1),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_we(mem_we_a),
        .mem_rdata(rd_l1), .locked(locked_a)
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3), .MAX_HOLD(MAXH)) u_dut3 (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0_b), .rvalid0(rvalid0_b), .rdata0(rdata0_b),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rdata1(rdata1_b),
        .lock1(lock1),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b),
        .mem_rdata(rd_l3[2]), .locked(locked_b)
    );

    // Power-up contents of the memory: derived from the address, with one marked word.
    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        if (a == 14'h0010) return 32'hDEADBEEF;
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [DW-1:0] tb_read(input logic [AW-1:0] a);
        return tb_wr[a] ? tb_mem[a] : init_word(a);
    endfunction

    // Synchronous memory shared by both instances; read data delayed by 1 and 3 cycles.
    always @(posedge clk) begin
        rd_l1    <= tb_read(mem_addr_a);
        rd_l3[0] <= tb_read(mem_addr_a);
        rd_l3[1] <= rd_l3[0];
        rd_l3[2] <= rd_l3[1];
        if (mem_we_a) begin
            tb_mem[mem_addr_a] <= mem_wdata_a;
            tb_wr[mem_addr_a]  <= 1'b1;
        end
    end

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int last_g  = -1;

    // Reference model state: lock flag, who went last, locked grants so far.
    bit            m_lock = 1'b0;
    int            m_last = 1;
    int            m_hold = 0;
    bit            h_rst [0:HN-1];
    bit            h_rv  [0:HN-1];
    bit            h_id  [0:HN-1];
    logic [DW-1:0] h_dat [0:HN-1];
    logic [DW-1:0] mmem  [int];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_port(input string tag, input logic g0, input logic g1, input logic we,
                              input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic lk,
                              input int g, input logic [AW-1:0] ea, input logic [DW-1:0] ewd,
                              input logic ewe, input logic elk);
        chk({tag, "_gnt0"}, 32'(g0), 32'(g == 0));
        chk({tag, "_gnt1"}, 32'(g1), 32'(g == 1));
        chk({tag, "_mem_we"}, 32'(we), 32'(ewe));
        chk({tag, "_mem_addr"}, 32'(a), 32'(ea));
        chk({tag, "_mem_wdata"}, wd, ewd);
        chk({tag, "_locked"}, 32'(lk), 32'(elk));
    endtask

    // A read issued in cycle c returns in cycle c+lat unless reset is seen in (c, c+lat].
    task automatic check_return(input string tag, input int lat, input logic rv0, input logic rv1,
                                input logic [DW-1:0] rd0, input logic [DW-1:0] rd1);
        bit            ev;
        bit            eid;
        logic [DW-1:0] ed;
        ev  = 1'b0;
        eid = 1'b0;
        ed  = '0;
        if (cyc >= lat) begin
            ev  = h_rv[cyc-lat];
            eid = h_id[cyc-lat];
            ed  = h_dat[cyc-lat];
            for (int j = cyc - lat + 1; j <= cyc; j++)
                if (h_rst[j]) ev = 1'b0;
        end
        chk({tag, "_rvalid0"}, 32'(rv0), 32'(ev && !eid));
        chk({tag, "_rvalid1"}, 32'(rv1), 32'(ev && eid));
        if (ev) chk({tag, "_rdata"}, eid ? rd1 : rd0, ed);
    endtask

    // One clock cycle: predict, compare on the falling edge, advance the model.
    task automatic run_cycle();
        int            g;
        logic          ewe, elk;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        @(negedge clk);
        if (cyc >= HN) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, HN);
            n_bad++;
            $display("test done: total=%0d bad=%0d", n_total, n_bad);
            $fatal(1, "cycle budget exceeded");
        end
        h_rst[cyc] = rst;
        elk = m_lock && !rst;
        g   = -1;
        if (rst) begin
            m_lock = 1'b0;
            m_last = 1;
            m_hold = 0;
        end else if (!m_lock) begin
            if (req0 && req1) g = (m_last == 1) ? 0 : 1;
            else if (req0)    g = 0;
            else if (req1)    g = 1;
            if (g >= 0) m_last = g;
            if (g == 1 && lock1) begin
                m_lock = 1'b1;
                m_hold = 1;
            end
        end else begin
            if (req1 && (m_hold < MAXH || !req0)) begin
                g = 1;
                if (m_hold < MAXH) m_hold++;
                if (!lock1) m_lock = 1'b0;
            end else begin
                m_lock = 1'b0;
                m_last = req0 ? 0 : 1;
                if (req0) g = 0;
            end
        end
        ea  = (g == 0) ? addr0  : (g == 1) ? addr1  : '0;
        ewd = (g == 0) ? wdata0 : (g == 1) ? wdata1 : '0;
        ewe = (g == 0) ? we0    : (g == 1) ? we1    : 1'b0;
        check_port("l1", gnt0_a, gnt1_a, mem_we_a, mem_addr_a, mem_wdata_a, locked_a, g, ea, ewd, ewe, elk);
        check_port("l3", gnt0_b, gnt1_b, mem_we_b, mem_addr_b, mem_wdata_b, locked_b, g, ea, ewd, ewe, elk);
        check_return("l1", 1, rvalid0_a, rvalid1_a, rdata0_a, rdata1_a);
        check_return("l3", 3, rvalid0_b, rvalid1_b, rdata0_b, rdata1_b);
        h_rv[cyc]  = (g >= 0) && !ewe;
        h_id[cyc]  = (g == 1);
        h_dat[cyc] = mmem.exists(int'(ea)) ? mmem[int'(ea)] : init_word(ea);
        if (g >= 0 && ewe) mmem[int'(ea)] = ewd;
        last_g = g;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                          input logic l1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        lock1 = l1;
    endtask

    task automatic idle(input int n);
        set_in(0, 0, '0, '0, 0, 0, '0, '0, 0);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, '0, '0, 0, 0, '0, '0, 0);
        run_cycle();
        run_cycle();
        rst = 1'b0;

        // lone read from requester 0
        set_in(1, 0, 14'h0010, '0, 0, 0, '0, '0, 0);
        run_cycle();
        idle(4);

        // continuous writes from both: alternation starting at 0 after reset
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        set_in(1, 1, 14'h0001, 32'hA0A00001, 1, 1, 14'h0002, 32'hB0B00002, 0);
        for (int i = 0; i < 6; i++) run_cycle();

        // lock held past the hold budget with requester 0 waiting throughout
        set_in(1, 1, 14'h0003, 32'h00000033, 0, 0, '0, '0, 0);
        run_cycle();
        set_in(1, 1, 14'h0003, 32'h00000033, 1, 1, 14'h0004, 32'h00000044, 1);
        for (int i = 0; i < 12; i++) run_cycle();
        lock1 = 1'b0;
        for (int i = 0; i < 4; i++) run_cycle();

        // interleaved back-to-back reads 0,1,0
        set_in(1, 0, 14'h0007, '0, 0, 0, '0, '0, 0);
        run_cycle();
        set_in(0, 0, '0, '0, 1, 0, 14'h0008, '0, 0);
        run_cycle();
        set_in(1, 0, 14'h0009, '0, 0, 0, '0, '0, 0);
        run_cycle();
        idle(4);

        // reset right after a locked read
        set_in(0, 0, '0, '0, 1, 0, 14'h0005, '0, 1);
        run_cycle();
        rst = 1'b1;
        set_in(1, 0, 14'h0006, '0, 1, 0, 14'h0005, '0, 1);
        run_cycle();
        rst = 1'b0;
        run_cycle();
        idle(4);

        // write through requester 1 then read back through requester 0
        set_in(0, 0, '0, '0, 1, 1, 14'h3FFF, 32'h12345678, 0);
        run_cycle();
        set_in(1, 0, 14'h3FFF, '0, 0, 0, '0, '0, 0);
        run_cycle();
        idle(4);

        // random traffic; a pending request stays put until the model grants it
        for (int i = 0; i < 600; i++) begin
            if (!req0 || last_g == 0) begin
                req0   = ($urandom % 3) != 0;
                we0    = 1'($urandom % 2);
                addr0  = AW'($urandom % 16);
                wdata0 = $urandom;
            end
            if (!req1 || last_g == 1) begin
                req1   = ($urandom % 3) != 0;
                we1    = 1'($urandom % 2);
                addr1  = AW'($urandom % 16);
                wdata1 = $urandom;
            end
            lock1 = ($urandom % 4) != 0;
            rst   = ($urandom % 60) == 0;
            run_cycle();
        end
        rst = 1'b0;
        idle(4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
